// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - golden-model response checker for the ALU stimulus interface
//
// Consumes the same operand/control vector that drives the ALU together with the ALU's
// Result/zero, recomputes the expected result and keeps pass/fail statistics plus a
// snapshot of the first mismatching vector.
//
// Ports:
//   CLK, Reset                  clock (rising edge), asynchronous active-high reset
//   start                       pulse: clear stats/snapshot and (re)enter RUN
//   vec_valid, vec_last         vector present / final vector of the run
//   ReadData1, ReadData2, Ext,
//   Sa, ALUop, ALUSrcA, ALUSrcB operand/control vector as driven to the ALU
//   Result, zero                ALU response under test
//   vec_ready, busy, done       RUN / RUN-or-DRAIN / DONE status
//   error                       at least one mismatch scored
//   pass_cnt, fail_cnt          saturating match / mismatch counters
//   fail_idx, fail_got,
//   fail_exp                    snapshot of the first mismatch since start

module alu_result_checker #(
    parameter int CNT_W        = 16,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic             vec_valid,
    input  logic             vec_last,
    input  logic [31:0]      ReadData1,
    input  logic [31:0]      ReadData2,
    input  logic [31:0]      Ext,
    input  logic [31:0]      Sa,
    input  logic [2:0]       ALUop,
    input  logic             ALUSrcA,
    input  logic             ALUSrcB,
    input  logic [31:0]      Result,
    input  logic             zero,
    output logic             vec_ready,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] fail_idx,
    output logic [31:0]      fail_got,
    output logic [31:0]      fail_exp
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             r_state;
    logic               r_s1_valid;
    logic [CNT_W-1:0]   r_s1_idx;
    logic [31:0]        r_s1_exp;
    logic [31:0]        r_s1_got;
    logic               r_s1_zero;
    logic [CNT_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_pass_cnt;
    logic [CNT_W-1:0]   r_fail_cnt;
    logic [CNT_W-1:0]   r_fail_idx;
    logic [31:0]        r_fail_got;
    logic [31:0]        r_fail_exp;

    logic [31:0]        w_a;
    logic [31:0]        w_b;
    logic [31:0]        w_exp;
    logic               w_accept;
    logic               w_mismatch;
    logic               w_stop;

    // Golden result for the vector currently on the inputs.
    assign w_a = ALUSrcA ? Sa  : ReadData1;
    assign w_b = ALUSrcB ? Ext : ReadData2;

    always_comb begin
        w_exp = 32'd0;
        case (ALUop)
            3'b000: w_exp = w_a + w_b;
            3'b001: w_exp = w_a - w_b;
            3'b010: w_exp = w_b << w_a[4:0];
            3'b011: w_exp = w_a | w_b;
            3'b100: w_exp = w_a & w_b;
            3'b101: w_exp = {31'd0, (w_a < w_b)};
            3'b110: w_exp = {31'd0, ($signed(w_a) < $signed(w_b))};
            default: w_exp = ~(w_a | w_b);
        endcase
    end

    assign w_accept   = vec_valid && (r_state == S_RUN);
    assign w_mismatch = (r_s1_got != r_s1_exp) || (r_s1_zero != (r_s1_exp == 32'd0));
    // Stage 1 is only ever valid in RUN or DRAIN, so this covers both exits to DONE.
    assign w_stop     = STOP_ON_FAIL && r_s1_valid && w_mismatch;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_s1_exp   <= '0;
            r_s1_got   <= '0;
            r_s1_zero  <= 1'b0;
            r_idx      <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_fail_idx <= '0;
            r_fail_got <= '0;
            r_fail_exp <= '0;
        end else if (start) begin
            // start wins over everything, including a vector offered this cycle.
            r_state    <= S_RUN;
            r_s1_valid <= 1'b0;
            r_idx      <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_fail_idx <= '0;
            r_fail_got <= '0;
            r_fail_exp <= '0;
        end else begin
            // Stage 2: score whatever stage 1 holds.
            if (r_s1_valid) begin
                if (w_mismatch) begin
                    // fail_cnt is still zero exactly when no mismatch has been seen yet.
                    if (r_fail_cnt == '0) begin
                        r_fail_idx <= r_s1_idx;
                        r_fail_got <= r_s1_got;
                        r_fail_exp <= r_s1_exp;
                    end
                    if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + CNT_ONE;
                end else if (r_pass_cnt != CNT_MAX) begin
                    r_pass_cnt <= r_pass_cnt + CNT_ONE;
                end
            end

            if (w_stop) begin
                // The vector arriving this cycle is discarded along with the run.
                r_state    <= S_DONE;
                r_s1_valid <= 1'b0;
            end else begin
                // Stage 1: capture the accepted vector with its golden result.
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_idx  <= r_idx;
                    r_s1_exp  <= w_exp;
                    r_s1_got  <= Result;
                    r_s1_zero <= zero;
                    r_idx     <= r_idx + CNT_ONE;
                end
                case (r_state)
                    S_RUN:   if (w_accept && vec_last) r_state <= S_DRAIN;
                    S_DRAIN: r_state <= S_DONE;
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign vec_ready = (r_state == S_RUN);
    assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign error     = (r_fail_cnt != '0);
    assign pass_cnt  = r_pass_cnt;
    assign fail_cnt  = r_fail_cnt;
    assign fail_idx  = r_fail_idx;
    assign fail_got  = r_fail_got;
    assign fail_exp  = r_fail_exp;

endmodule

// File: tb/tb_alu_result_checker.sv
// tb/tb_alu_result_checker.sv - randomized self-checking bench for alu_result_checker

module tb_alu_result_checker;

    logic        CLK = 1'b0;
    logic        Reset, start, vec_valid, vec_last;
    logic [31:0] ReadData1, ReadData2, Ext, Sa, Result;
    logic [2:0]  ALUop;
    logic        ALUSrcA, ALUSrcB, zero;

    logic        d0_vec_ready, d0_busy, d0_done, d0_error;
    logic [15:0] d0_pass_cnt, d0_fail_cnt, d0_fail_idx;
    logic [31:0] d0_fail_got, d0_fail_exp;
    logic        d1_vec_ready, d1_busy, d1_done, d1_error;
    logic [15:0] d1_pass_cnt, d1_fail_cnt, d1_fail_idx;
    logic [31:0] d1_fail_got, d1_fail_exp;

    alu_result_checker #(.CNT_W(16), .STOP_ON_FAIL(1'b0)) u_dut (
        .CLK(CLK), .Reset(Reset), .start(start), .vec_valid(vec_valid), .vec_last(vec_last),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .Ext(Ext), .Sa(Sa), .ALUop(ALUop),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .Result(Result), .zero(zero),
        .vec_ready(d0_vec_ready), .busy(d0_busy), .done(d0_done), .error(d0_error),
        .pass_cnt(d0_pass_cnt), .fail_cnt(d0_fail_cnt), .fail_idx(d0_fail_idx),
        .fail_got(d0_fail_got), .fail_exp(d0_fail_exp)
    );

    alu_result_checker #(.CNT_W(16), .STOP_ON_FAIL(1'b1)) u_dut_sof (
        .CLK(CLK), .Reset(Reset), .start(start), .vec_valid(vec_valid), .vec_last(vec_last),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .Ext(Ext), .Sa(Sa), .ALUop(ALUop),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .Result(Result), .zero(zero),
        .vec_ready(d1_vec_ready), .busy(d1_busy), .done(d1_done), .error(d1_error),
        .pass_cnt(d1_pass_cnt), .fail_cnt(d1_fail_cnt), .fail_idx(d1_fail_idx),
        .fail_got(d1_fail_got), .fail_exp(d1_fail_exp)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state for the STOP_ON_FAIL=0 instance.
    bit          m_run = 1'b0;
    int          m_idx, m_pass, m_fail, m_fidx;
    logic [31:0] m_fgot, m_fexp;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Expected ALU result, computed with wide integer arithmetic.
    function automatic logic [31:0] golden(input logic [2:0] op, input logic sas, input logic sbs,
                                           input logic [31:0] rd1, input logic [31:0] rd2,
                                           input logic [31:0] ext, input logic [31:0] sa);
        longint unsigned a, b, r;
        longint          as_s, bs_s;
        a = sas ? 64'(sa)  : 64'(rd1);
        b = sbs ? 64'(ext) : 64'(rd2);
        as_s = (a >= 64'd2147483648) ? longint'(a) - 64'sd4294967296 : longint'(a);
        bs_s = (b >= 64'd2147483648) ? longint'(b) - 64'sd4294967296 : longint'(b);
        case (op)
            3'd0: r = a + b;
            3'd1: r = a + 64'd4294967296 - b;
            3'd2: r = b * (64'd1 << (a % 64'd32));
            3'd3: r = a | b;
            3'd4: r = a & b;
            3'd5: r = (a < b) ? 64'd1 : 64'd0;
            3'd6: r = (as_s < bs_s) ? 64'd1 : 64'd0;
            default: r = 64'd4294967295 - (a | b);
        endcase
        return 32'(r % 64'd4294967296);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_clear();
        m_idx = 0; m_pass = 0; m_fail = 0; m_fidx = 0; m_fgot = '0; m_fexp = '0;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
        m_run = 1'b1;
    endtask

    task automatic send(input logic [2:0] op, input logic sas, input logic sbs,
                        input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] ext, input logic [31:0] sa,
                        input logic [31:0] res, input logic z, input logic last);
        logic [31:0] exp;
        ALUop = op; ALUSrcA = sas; ALUSrcB = sbs;
        ReadData1 = rd1; ReadData2 = rd2; Ext = ext; Sa = sa;
        Result = res; zero = z; vec_valid = 1'b1; vec_last = last;
        tick();
        vec_valid = 1'b0; vec_last = 1'b0;
        if (m_run) begin
            exp = golden(op, sas, sbs, rd1, rd2, ext, sa);
            if (res !== exp || z !== (exp == 32'd0)) begin
                if (m_fail == 0) begin
                    m_fidx = m_idx; m_fgot = res; m_fexp = exp;
                end
                m_fail++;
            end else begin
                m_pass++;
            end
            m_idx++;
            if (last) m_run = 1'b0;
        end
    endtask

    task automatic send_good(input logic [2:0] op, input logic sas, input logic sbs,
                             input logic [31:0] rd1, input logic [31:0] rd2,
                             input logic [31:0] ext, input logic [31:0] sa, input logic last);
        logic [31:0] exp;
        exp = golden(op, sas, sbs, rd1, rd2, ext, sa);
        send(op, sas, sbs, rd1, rd2, ext, sa, exp, exp == 32'd0, last);
    endtask

    task automatic wait_done0(input string tag);
        for (int i = 0; i < 20 && !d0_done; i++) tick();
        check_val(tag, 32'(d0_done), 32'd1);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        logic [31:0] res, exp, sa_v;
        logic [2:0]  op;
        logic        sas, sbs, z;

        Reset = 1'b1; start = 1'b0; vec_valid = 1'b0; vec_last = 1'b0;
        ReadData1 = '0; ReadData2 = '0; Ext = '0; Sa = '0; Result = '0;
        ALUop = '0; ALUSrcA = 1'b0; ALUSrcB = 1'b0; zero = 1'b0;
        tick(); tick();

        check_val("rst_vec_ready", 32'(d0_vec_ready), 32'd0);
        check_val("rst_busy",      32'(d0_busy),      32'd0);
        check_val("rst_done",      32'(d0_done),      32'd0);
        check_val("rst_error",     32'(d0_error),     32'd0);
        check_val("rst_pass",      32'(d0_pass_cnt),  32'd0);
        check_val("rst_fail",      32'(d0_fail_cnt),  32'd0);
        check_val("rst_fidx",      32'(d0_fail_idx),  32'd0);
        check_val("rst_fgot",      d0_fail_got,       32'd0);
        check_val("rst_fexp",      d0_fail_exp,       32'd0);
        check_val("rst_sof_ready", 32'(d1_vec_ready), 32'd0);

        Reset = 1'b0;
        // Vectors in IDLE are dropped.
        for (int i = 0; i < 3; i++) send(3'd0, 1'b0, 1'b0, 1, 2, 0, 0, 32'd7, 1'b0, 1'b0);
        tick(); tick();
        check_val("idle_pass",  32'(d0_pass_cnt),  32'd0);
        check_val("idle_fail",  32'(d0_fail_cnt),  32'd0);
        check_val("idle_ready", 32'(d0_vec_ready), 32'd0);

        // Directed: add, then sub pass and sub with wrong zero flag.
        start_run();
        check_val("run_ready", 32'(d0_vec_ready), 32'd1);
        check_val("run_busy",  32'(d0_busy),      32'd1);
        send(3'd0, 1'b1, 1'b1, 0, 0, 1, 1, 32'd2, 1'b0, 1'b0);
        check_val("add_lat1", 32'(d0_pass_cnt), 32'd0);
        tick();
        check_val("add_lat2", 32'(d0_pass_cnt), 32'd1);
        send(3'd1, 1'b0, 1'b0, 1, 2, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        send(3'd1, 1'b0, 1'b0, 1, 2, 0, 0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        tick(); tick();
        check_val("sub_pass",  32'(d0_pass_cnt), 32'd2);
        check_val("sub_fail",  32'(d0_fail_cnt), 32'd1);
        check_val("sub_fexp",  d0_fail_exp,      32'hFFFF_FFFF);
        check_val("sub_fgot",  d0_fail_got,      32'hFFFF_FFFF);
        check_val("sub_fidx",  32'(d0_fail_idx), 32'd2);
        check_val("sub_error", 32'(d0_error),    32'd1);
        // A later mismatch must not disturb the snapshot.
        send(3'd0, 1'b0, 1'b0, 5, 6, 0, 0, 32'd12, 1'b0, 1'b0);
        tick(); tick();
        check_val("snap_fail", 32'(d0_fail_cnt), 32'd2);
        check_val("snap_fidx", 32'(d0_fail_idx), 32'd2);
        check_val("snap_fgot", d0_fail_got,      32'hFFFF_FFFF);

        // Sweep all ops x source selects; three responses are spec constants.
        start_run();
        for (int i = 0; i < 32; i++) begin
            op  = 3'(i / 4);
            sas = 1'((i % 4) / 2);
            sbs = 1'(i % 2);
            res = golden(op, sas, sbs, 1, 2, 2, 4);
            if (op == 3'd2 && sas && sbs)   res = 32'h20;
            if (op == 3'd6 && !sas && !sbs) res = 32'h1;
            if (op == 3'd7 && !sas && !sbs) res = 32'hFFFF_FFFC;
            send(op, sas, sbs, 1, 2, 2, 4, res, res == 32'd0, i == 31);
        end
        check_val("drain_busy", 32'(d0_busy), 32'd1);
        check_val("drain_done", 32'(d0_done), 32'd0);
        tick();
        check_val("sweep_done",  32'(d0_done),      32'd1);
        check_val("sweep_pass",  32'(d0_pass_cnt),  32'd32);
        check_val("sweep_model", 32'(d0_pass_cnt),  32'(m_pass));
        check_val("sweep_error", 32'(d0_error),     32'd0);
        check_val("sweep_ready", 32'(d0_vec_ready), 32'd0);
        send_good(3'd0, 1'b0, 1'b0, 1, 1, 0, 0, 1'b0);
        tick();
        check_val("done_hold_pass", 32'(d0_pass_cnt), 32'd32);
        check_val("done_hold",      32'(d0_done),     32'd1);

        // Randomized run with occasional corrupted responses and idle gaps.
        start_run();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            op   = 3'($urandom_range(0, 7));
            sas  = 1'($urandom_range(0, 1));
            sbs  = 1'($urandom_range(0, 1));
            sa_v = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : rand_operand();
            ReadData1 = rand_operand(); ReadData2 = rand_operand(); Ext = rand_operand();
            exp = golden(op, sas, sbs, ReadData1, ReadData2, Ext, sa_v);
            res = exp;
            z   = (exp == 32'd0);
            case ($urandom_range(0, 7))
                0: res = exp ^ (32'd1 << $urandom_range(0, 31));
                1: z   = ~z;
                default: ;
            endcase
            send(op, sas, sbs, ReadData1, ReadData2, Ext, sa_v, res, z, i == 149);
        end
        wait_done0("rnd_done");
        check_val("rnd_pass",  32'(d0_pass_cnt), 32'(m_pass));
        check_val("rnd_fail",  32'(d0_fail_cnt), 32'(m_fail));
        check_val("rnd_error", 32'(d0_error),    32'(m_fail != 0));
        if (m_fail != 0) begin
            check_val("rnd_fidx", 32'(d0_fail_idx), 32'(m_fidx));
            check_val("rnd_fgot", d0_fail_got,      m_fgot);
            check_val("rnd_fexp", d0_fail_exp,      m_fexp);
        end

        // STOP_ON_FAIL: bad Result on vector 3 of 10.
        start_run();
        for (int i = 0; i < 10; i++) begin
            res = golden(3'd0, 1'b0, 1'b0, 32'(i), 32'(i), 0, 0);
            if (i == 3) res = res ^ 32'h1;
            send(3'd0, 1'b0, 1'b0, 32'(i), 32'(i), 0, 0, res, res == 32'd0, i == 9);
            if (i == 3) check_val("sof_not_yet", 32'(d1_done), 32'd0);
            if (i == 4) begin
                check_val("sof_done",  32'(d1_done),      32'd1);
                check_val("sof_fidx",  32'(d1_fail_idx),  32'd3);
                check_val("sof_pass",  32'(d1_pass_cnt),  32'd3);
                check_val("sof_fail",  32'(d1_fail_cnt),  32'd1);
                check_val("sof_fgot",  d1_fail_got,       32'd7);
                check_val("sof_ready", 32'(d1_vec_ready), 32'd0);
            end
        end
        tick(); tick();
        check_val("sof_pass_hold", 32'(d1_pass_cnt), 32'd3);
        check_val("sof_fail_hold", 32'(d1_fail_cnt), 32'd1);
        wait_done0("nosof_done");
        check_val("nosof_pass", 32'(d0_pass_cnt), 32'd9);
        check_val("nosof_fail", 32'(d0_fail_cnt), 32'd1);
        check_val("nosof_fidx", 32'(d0_fail_idx), 32'd3);

        // start with a same-cycle vector while running.
        start_run();
        for (int i = 0; i < 3; i++) send_good(3'd3, 1'b0, 1'b0, 32'(i), 5, 0, 0, 1'b0);
        start = 1'b1;
        ALUop = 3'd0; ALUSrcA = 1'b0; ALUSrcB = 1'b0; ReadData1 = 3; ReadData2 = 4;
        Result = 32'd7; zero = 1'b0; vec_valid = 1'b1;
        tick();
        start = 1'b0; vec_valid = 1'b0;
        model_clear(); m_run = 1'b1;
        tick(); tick();
        check_val("restart_pass",  32'(d0_pass_cnt),  32'd0);
        check_val("restart_fail",  32'(d0_fail_cnt),  32'd0);
        check_val("restart_ready", 32'(d0_vec_ready), 32'd1);
        send(3'd4, 1'b0, 1'b0, 32'hF0, 32'h3C, 0, 0, 32'h0, 1'b0, 1'b0);
        tick(); tick();
        check_val("restart_fidx", 32'(d0_fail_idx), 32'd0);
        check_val("restart_fexp", d0_fail_exp,      32'h30);

        // Asynchronous reset mid-run.
        start_run();
        send_good(3'd0, 1'b0, 1'b0, 1, 1, 0, 0, 1'b0);
        send_good(3'd0, 1'b0, 1'b0, 2, 2, 0, 0, 1'b0);
        #2 Reset = 1'b1;
        #1;
        check_val("arst_pass",  32'(d0_pass_cnt),  32'd0);
        check_val("arst_busy",  32'(d0_busy),      32'd0);
        check_val("arst_ready", 32'(d0_vec_ready), 32'd0);
        m_run = 1'b0;
        tick();
        Reset = 1'b0;
        tick();
        check_val("arst_idle_busy", 32'(d0_busy), 32'd0);
        check_val("arst_idle_done", 32'(d0_done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
